// File: rtl/spi_frame_slave.sv
// SPI mode-0 register-frame slave: snapshots positions/inputs at select and
// commits received velocities, outputs and config only on a length- and checksum-valid frame.
module spi_frame_slave #(
    parameter int N  = 4,
    parameter int PW = 21,
    parameter int VW = 16,
    parameter int DW = 14,
    parameter int IW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              ssel,
    input  logic              mosi,
    output logic              miso,
    input  logic [N*PW-1:0]   pos,
    input  logic [IW-1:0]     din,
    output logic [N*VW-1:0]   vel,
    output logic [DW-1:0]     dout,
    output logic [15:0]       cfg,
    output logic              wdt_kick,
    output logic              frame_ok,
    output logic              frame_err,
    output logic [7:0]        err_cnt
);

    localparam int FL = 4 * N + 6;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_CHECK} state_t;

    state_t          r_state, w_state_nx;
    logic [2:0]      r_sck_s, r_ssel_s, r_settle;
    logic [1:0]      r_mosi_s;
    logic            r_armed;
    logic [6:0]      r_rx;
    logic [2:0]      r_bit;
    logic [5:0]      r_byte_cnt;
    logic [7:0]      r_csum, r_rx_csum, r_tx, r_tx_csum;
    logic            r_cmd0;
    logic [7:0]      r_vel_lo [N];
    logic [VW-1:0]   r_vel_sh [N];
    logic [7:0]      r_dout_lo, r_cfg0;
    logic [DW-1:0]   r_dout_sh;
    logic [15:0]     r_cfg_sh;
    logic [N*PW-1:0] r_pos_snap;
    logic [IW-1:0]   r_din_snap;
    logic [1:0]      r_stat_snap;
    logic [7:0]      r_errc_snap;
    logic            r_last_ok, r_last_err;
    logic [N*VW-1:0] r_vel;
    logic [DW-1:0]   r_dout;
    logic [15:0]     r_cfg;
    logic            r_kick, r_ok, r_err;
    logic [7:0]      r_err_cnt;

    logic            w_sck_rise, w_sck_fall, w_ssel_fall, w_ssel_rise;
    logic            w_enter, w_good, w_bare, w_commit, w_reject;
    logic [7:0]      w_rx_byte, w_tx_byte;
    logic [6:0]      w_nidx;
    logic [23:0]     w_p;
    logic [15:0]     w_din16;

    assign w_sck_rise  = r_sck_s[1] & ~r_sck_s[2];
    assign w_sck_fall  = ~r_sck_s[1] & r_sck_s[2];
    assign w_ssel_fall = r_armed & r_ssel_s[2] & ~r_ssel_s[1];
    assign w_ssel_rise = ~r_ssel_s[2] & r_ssel_s[1];
    assign w_rx_byte   = {r_rx, r_mosi_s[1]};
    assign w_nidx      = {1'b0, r_byte_cnt} + 7'd1;
    assign w_din16     = 16'(r_din_snap);

    // NOTE: the ssel synchroniser resets to "deselected", which would look like a
    // falling edge if the pin is already low; r_armed blocks that until ssel is seen high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sck_s  <= 3'b000;
            r_ssel_s <= 3'b111;
            r_mosi_s <= 2'b00;
            r_settle <= 3'b000;
            r_armed  <= 1'b0;
        end else begin
            r_sck_s  <= {r_sck_s[1:0], sck};
            r_ssel_s <= {r_ssel_s[1:0], ssel};
            r_mosi_s <= {r_mosi_s[0], mosi};
            r_settle <= {r_settle[1:0], 1'b1};
            if (r_settle[2] && r_ssel_s[2]) r_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nx = r_state;
        w_enter    = 1'b0;
        w_commit   = 1'b0;
        w_reject   = 1'b0;
        w_good     = (r_byte_cnt == 6'(FL)) && (r_bit == 3'd0) && (r_rx_csum == r_csum);
        w_bare     = (r_byte_cnt == 6'd0) && (r_bit == 3'd0);
        case (r_state)
            S_IDLE: if (w_ssel_fall) begin
                w_state_nx = S_ACTIVE;
                w_enter    = 1'b1;
            end
            S_ACTIVE: if (w_ssel_rise) w_state_nx = S_CHECK;
            S_CHECK: begin
                w_state_nx = S_IDLE;
                w_commit   = w_good;
                w_reject   = !w_good && !w_bare;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Next MISO byte, selected by the index of the byte about to be shifted out.
    always_comb begin
        w_tx_byte = 8'h00;
        w_p       = 24'h0;
        for (int k = 0; k < N; k++) begin
            w_p         = 24'h0;
            w_p[PW-1:0] = r_pos_snap[k*PW +: PW];
            if (w_nidx == 7'(1 + 4*k)) w_tx_byte = w_p[7:0];
            if (w_nidx == 7'(2 + 4*k)) w_tx_byte = w_p[15:8];
            if (w_nidx == 7'(3 + 4*k)) w_tx_byte = w_p[23:16];
        end
        if (w_nidx == 7'(4*N + 1)) w_tx_byte = w_din16[7:0];
        if (w_nidx == 7'(4*N + 2)) w_tx_byte = w_din16[15:8];
        if (w_nidx == 7'(4*N + 3)) w_tx_byte = {6'b0, r_stat_snap};
        if (w_nidx == 7'(4*N + 4)) w_tx_byte = r_errc_snap;
        if (w_nidx == 7'(FL - 1))  w_tx_byte = r_tx_csum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx        <= '0;
            r_bit       <= '0;
            r_byte_cnt  <= '0;
            r_csum      <= '0;
            r_rx_csum   <= '0;
            r_tx        <= '0;
            r_tx_csum   <= '0;
            r_cmd0      <= 1'b0;
            r_dout_lo   <= '0;
            r_cfg0      <= '0;
            r_dout_sh   <= '0;
            r_cfg_sh    <= '0;
            r_pos_snap  <= '0;
            r_din_snap  <= '0;
            r_stat_snap <= '0;
            r_errc_snap <= '0;
            r_last_ok   <= 1'b0;
            r_last_err  <= 1'b0;
            r_vel       <= '0;
            r_dout      <= '0;
            r_cfg       <= '0;
            r_kick      <= 1'b0;
            r_ok        <= 1'b0;
            r_err       <= 1'b0;
            r_err_cnt   <= '0;
            for (int k = 0; k < N; k++) begin
                r_vel_lo[k] <= '0;
                r_vel_sh[k] <= '0;
            end
        end else begin
            r_ok   <= w_commit;
            r_err  <= w_reject;
            r_kick <= w_commit & r_cmd0;

            if (w_enter) begin
                r_pos_snap  <= pos;
                r_din_snap  <= din;
                r_stat_snap <= {r_last_err, r_last_ok};
                r_errc_snap <= r_err_cnt;
                r_byte_cnt  <= '0;
                r_bit       <= '0;
                r_csum      <= '0;
                r_tx        <= 8'hA5;
                r_tx_csum   <= 8'hA5;
            end

            if (r_state == S_ACTIVE) begin
                if (w_sck_rise) begin
                    r_rx  <= w_rx_byte[6:0];
                    r_bit <= r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        if (r_byte_cnt != 6'd63)        r_byte_cnt <= r_byte_cnt + 6'd1;
                        if (r_byte_cnt < 6'(FL - 1))   r_csum     <= r_csum ^ w_rx_byte;
                        if (r_byte_cnt == 6'(FL - 1))  r_rx_csum  <= w_rx_byte;
                        if (r_byte_cnt == 6'd0)        r_cmd0     <= w_rx_byte[0];
                        for (int k = 0; k < N; k++) begin
                            if (r_byte_cnt == 6'(1 + 4*k)) r_vel_lo[k] <= w_rx_byte;
                            if (r_byte_cnt == 6'(2 + 4*k)) r_vel_sh[k] <= VW'({w_rx_byte, r_vel_lo[k]});
                        end
                        if (r_byte_cnt == 6'(4*N + 1)) r_dout_lo <= w_rx_byte;
                        if (r_byte_cnt == 6'(4*N + 2)) r_dout_sh <= DW'({w_rx_byte, r_dout_lo});
                        if (r_byte_cnt == 6'(4*N + 3)) r_cfg0    <= w_rx_byte;
                        if (r_byte_cnt == 6'(4*N + 4)) r_cfg_sh  <= {w_rx_byte, r_cfg0};
                        r_tx <= w_tx_byte;
                        if (w_nidx < 7'(FL - 1)) r_tx_csum <= r_tx_csum ^ w_tx_byte;
                    end
                end else if (w_sck_fall && r_bit != 3'd0) begin
                    // A freshly loaded byte already presents its MSB, so the byte-boundary fall must not shift.
                    r_tx <= {r_tx[6:0], 1'b0};
                end
            end

            if (w_commit) begin
                for (int k = 0; k < N; k++) r_vel[k*VW +: VW] <= r_vel_sh[k];
                r_dout     <= r_dout_sh;
                r_cfg      <= r_cfg_sh;
                r_last_ok  <= 1'b1;
                r_last_err <= 1'b0;
            end
            if (w_reject) begin
                if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
                r_last_ok  <= 1'b0;
                r_last_err <= 1'b1;
            end
        end
    end

    assign miso      = r_tx[7];
    assign vel       = r_vel;
    assign dout      = r_dout;
    assign cfg       = r_cfg;
    assign wdt_kick  = r_kick;
    assign frame_ok  = r_ok;
    assign frame_err = r_err;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_spi_frame_slave.sv
// Directed bench for spi_frame_slave: good/bad/short/long frames, MISO snapshot
// coherence, mid-frame reset and error-counter saturation.
module tb_spi_frame_slave;

    localparam int N  = 4;
    localparam int PW = 21;
    localparam int VW = 16;
    localparam int DW = 14;
    localparam int IW = 16;
    localparam int FL = 4 * N + 6;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              sck = 1'b0;
    logic              ssel = 1'b1;
    logic              mosi = 1'b0;
    logic              miso;
    logic [N*PW-1:0]   pos;
    logic [N*PW-1:0]   pos_alt;
    logic [IW-1:0]     din;
    logic [N*VW-1:0]   vel;
    logic [DW-1:0]     dout;
    logic [15:0]       cfg;
    logic              wdt_kick, frame_ok, frame_err;
    logic [7:0]        err_cnt;

    spi_frame_slave #(.N(N), .PW(PW), .VW(VW), .DW(DW), .IW(IW)) dut (
        .clk(clk), .rst(rst), .sck(sck), .ssel(ssel), .mosi(mosi), .miso(miso),
        .pos(pos), .din(din), .vel(vel), .dout(dout), .cfg(cfg),
        .wdt_kick(wdt_kick), .frame_ok(frame_ok), .frame_err(frame_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ok_seen = 0, err_seen = 0, kick_seen = 0;
    int ok0, err0, kick0;

    logic [7:0] tx_buf  [0:31];
    logic [7:0] rx_buf  [0:31];
    logic [7:0] exp_miso[0:31];

    always @(negedge clk) begin
        if (frame_ok)  ok_seen   <= ok_seen + 1;
        if (frame_err) err_seen  <= err_seen + 1;
        if (wdt_kick)  kick_seen <= kick_seen + 1;
    end

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        ok0 = ok_seen; err0 = err_seen; kick0 = kick_seen;
    endtask

    task automatic check_pulses(input string tag, input int ok_d, input int err_d, input int kick_d);
        check({tag, "_ok"},   64'(ok_seen - ok0),     64'(ok_d));
        check({tag, "_err"},  64'(err_seen - err0),   64'(err_d));
        check({tag, "_kick"}, 64'(kick_seen - kick0), 64'(kick_d));
    endtask

    task automatic spi_byte(input logic [7:0] t, output logic [7:0] r);
        for (int i = 7; i >= 0; i--) begin
            mosi = t[i];
            clk_wait(5);
            sck  = 1'b1;
            r[i] = miso;
            clk_wait(5);
            sck  = 1'b0;
        end
    endtask

    task automatic send_frame(input int nbytes, input int chg_at, input int rst_at);
        logic [7:0] r;
        ssel = 1'b0;
        clk_wait(8);
        for (int b = 0; b < nbytes; b++) begin
            if (b == chg_at) pos = pos_alt;
            if (b == rst_at) begin
                rst = 1'b1;
                clk_wait(1);
                rst = 1'b0;
            end
            spi_byte(tx_buf[b], r);
            rx_buf[b] = r;
        end
        clk_wait(4);
        ssel = 1'b1;
        clk_wait(12);
    endtask

    function automatic void fill_frame(input logic [7:0] cmd, input logic [63:0] v,
                                       input logic [15:0] d, input logic [15:0] c,
                                       input logic [7:0] bad);
        logic [7:0] x;
        for (int i = 0; i < 32; i++) tx_buf[i] = 8'h00;
        tx_buf[0] = cmd;
        for (int k = 0; k < N; k++) begin
            tx_buf[1 + 4*k] = v[16*k +: 8];
            tx_buf[2 + 4*k] = v[16*k + 8 +: 8];
        end
        tx_buf[4*N + 1] = d[7:0];
        tx_buf[4*N + 2] = d[15:8];
        tx_buf[4*N + 3] = c[7:0];
        tx_buf[4*N + 4] = c[15:8];
        x = 8'h00;
        for (int i = 0; i < FL - 1; i++) x ^= tx_buf[i];
        tx_buf[FL - 1] = x ^ bad;
    endfunction

    function automatic void build_miso(input logic [N*PW-1:0] p, input logic [15:0] d,
                                       input logic [7:0] st, input logic [7:0] ec);
        logic [23:0] q;
        logic [7:0]  x;
        exp_miso[0] = 8'hA5;
        for (int k = 0; k < N; k++) begin
            q = 24'h0;
            q[PW-1:0] = p[k*PW +: PW];
            exp_miso[1 + 4*k] = q[7:0];
            exp_miso[2 + 4*k] = q[15:8];
            exp_miso[3 + 4*k] = q[23:16];
            exp_miso[4 + 4*k] = 8'h00;
        end
        exp_miso[4*N + 1] = d[7:0];
        exp_miso[4*N + 2] = d[15:8];
        exp_miso[4*N + 3] = st;
        exp_miso[4*N + 4] = ec;
        x = 8'h00;
        for (int i = 0; i < FL - 1; i++) x ^= exp_miso[i];
        exp_miso[FL - 1] = x;
    endfunction

    localparam logic [63:0] VEL_A = {16'hFFFF, 16'h0000, 16'h0000, 16'h1234};
    localparam logic [63:0] VEL_B = {16'h0001, 16'hA5A5, 16'h5A5A, 16'h8000};

    initial begin
        pos     = {21'h000100, 21'h1FFFFF, 21'h012345, 21'h0ABCDE};
        pos_alt = {21'h000100, 21'h1FFFFF, 21'h012345, 21'h000001};
        din     = 16'h1357;

        rst = 1'b1;
        clk_wait(3);
        rst = 1'b0;
        clk_wait(6);
        check("rst_miso", miso, 1'b0);
        check("rst_vel", vel, 64'h0);
        check("rst_dout", dout, 14'h0);
        check("rst_cfg", cfg, 16'h0);
        check("rst_err_cnt", err_cnt, 8'h0);
        check("rst_pulses", {wdt_kick, frame_ok, frame_err}, 3'b000);

        // Bare select: no bytes, no pulse.
        mark();
        ssel = 1'b0;
        clk_wait(20);
        ssel = 1'b1;
        clk_wait(12);
        check_pulses("bare", 0, 0, 0);

        // Good frame; pos0 changes mid-frame but the MISO snapshot must not.
        mark();
        fill_frame(8'h01, VEL_A, 16'h2ABC, 16'h0503, 8'h00);
        build_miso(pos, din, 8'h00, 8'h00);
        send_frame(FL, 5, -1);
        check_pulses("good", 1, 0, 1);
        check("good_vel0", vel[15:0], 16'h1234);
        check("good_vel3", vel[63:48], 16'hFFFF);
        check("good_vel", vel, VEL_A);
        check("good_dout", dout, 14'h2ABC);
        check("good_cfg", cfg, 16'h0503);
        check("miso_b0", rx_buf[0], 8'hA5);
        check("miso_b1", rx_buf[1], 8'hDE);
        check("miso_b2", rx_buf[2], 8'hBC);
        check("miso_b3", rx_buf[3], 8'h0A);
        check("miso_b4", rx_buf[4], 8'h00);
        for (int b = 5; b < FL; b++) check($sformatf("miso_model_b%0d", b), rx_buf[b], exp_miso[b]);

        // Checksum corrupted: rejected, prior commit intact, new pos now visible.
        mark();
        fill_frame(8'h01, VEL_B, 16'h1111, 16'h2222, 8'h01);
        send_frame(FL, -1, -1);
        check_pulses("csum", 0, 1, 0);
        check("csum_err_cnt", err_cnt, 8'd1);
        check("csum_vel", vel, VEL_A);
        check("csum_dout", dout, 14'h2ABC);
        check("csum_cfg", cfg, 16'h0503);
        check("csum_miso_pos_lo", rx_buf[1], 8'h01);
        check("csum_miso_pos_mid", rx_buf[2], 8'h00);
        check("csum_miso_status", rx_buf[19], 8'h01);

        // Short then long frame, both with a correct checksum in place.
        mark();
        fill_frame(8'h01, VEL_B, 16'h1111, 16'h2222, 8'h00);
        send_frame(10, -1, -1);
        send_frame(FL + 1, -1, -1);
        check_pulses("len", 0, 2, 0);
        check("len_err_cnt", err_cnt, 8'd3);
        check("len_vel", vel, VEL_A);
        check("len_miso_status", rx_buf[19], 8'h02);
        check("len_miso_errcnt", rx_buf[20], 8'h02);
        check("len_miso_past_fl", rx_buf[FL], 8'h00);

        // Good frame without watchdog bit; dout truncated to DW bits.
        mark();
        fill_frame(8'h00, VEL_B, 16'hFFFF, 16'h1234, 8'h00);
        build_miso(pos, din, 8'h02, 8'h03);
        send_frame(FL, -1, -1);
        check_pulses("good2", 1, 0, 0);
        check("good2_vel", vel, VEL_B);
        check("good2_dout", dout, 14'h3FFF);
        check("good2_cfg", cfg, 16'h1234);
        check("good2_miso_status", rx_buf[19], 8'h02);
        check("good2_miso_errcnt", rx_buf[20], 8'h03);
        check("good2_miso_csum", rx_buf[21], exp_miso[21]);

        // Reset at byte 7 with ssel held low: frame discarded, nothing commits.
        mark();
        fill_frame(8'h01, VEL_A, 16'h0F0F, 16'h7777, 8'h00);
        send_frame(FL, -1, 7);
        check_pulses("rstmid", 0, 0, 0);
        check("rstmid_vel", vel, 64'h0);
        check("rstmid_dout", dout, 14'h0);
        check("rstmid_cfg", cfg, 16'h0);
        check("rstmid_err_cnt", err_cnt, 8'h0);

        mark();
        fill_frame(8'h01, VEL_A, 16'h2ABC, 16'h0503, 8'h00);
        send_frame(FL, -1, -1);
        check_pulses("postrst", 1, 0, 1);
        check("postrst_vel", vel, VEL_A);
        check("postrst_cfg", cfg, 16'h0503);
        check("postrst_miso_status", rx_buf[19], 8'h00);
        check("postrst_miso_errcnt", rx_buf[20], 8'h00);

        // 260 one-byte frames saturate the error counter.
        mark();
        for (int i = 0; i < 260; i++) send_frame(1, -1, -1);
        check_pulses("sat", 0, 260, 0);
        check("sat_err_cnt", err_cnt, 8'hFF);
        fill_frame(8'h01, VEL_B, 16'h0000, 16'h0000, 8'h80);
        send_frame(FL, -1, -1);
        check("sat_miso_status", rx_buf[19], 8'h02);
        check("sat_miso_errcnt", rx_buf[20], 8'hFF);
        check("sat_err_cnt_hold", err_cnt, 8'hFF);
        check("sat_vel_hold", vel, VEL_A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
